// File: rtl/demux1x64_deser_pkg.sv
// Shared constants, FSM state encoding and the parity helper for the 1-to-64 deserializer.
package demux1x64_deser_pkg;

  localparam int MUX_SEL_W = 6;
  localparam int MUX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Even parity: 1 when the word holds an odd number of ones.
  function automatic logic even_par(input logic [MUX_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/demux1x64_deser_dec6to64.sv
// Index to one-hot write-enable decoder, gated by the beat-accept strobe.
module demux1x64_deser_dec6to64
  import demux1x64_deser_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  // One-hot decode of the write index
  always_comb begin
    onehot = {WIDTH{1'b0}};
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/demux1x64_deser.sv
// 1-to-64 bit deserializer with explicit or auto-increment indexing and a valid/ready word output.
// Optional build macro DEMUX64_PARITY_EN enables the registered even-parity output out_par.
module demux1x64_deser
  import demux1x64_deser_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] ptr,
  output logic             out_par
);

  state_t             state_r;
  logic [WIDTH-1:0]   mask_r;
  logic               accept_s;
  logic [SEL_W-1:0]   idx_s;
  logic [WIDTH-1:0]   we_s;
  logic [WIDTH-1:0]   mask_next_s;
  logic [WIDTH-1:0]   out_next_s;
  logic               full_s;

  assign accept_s    = in_valid & in_ready;
  assign idx_s       = auto ? ptr : sel;
  assign mask_next_s = mask_r | we_s;
  assign out_next_s  = (out & ~we_s) | ({WIDTH{in}} & we_s);
  assign full_s      = &mask_next_s;

  // The same one-hot strobe writes the data bit and marks the index as filled
  demux1x64_deser_dec6to64 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_dec (
    .idx    (idx_s),
    .en     (accept_s),
    .onehot (we_s)
  );

  // Beats are accepted in every state except while a finished word waits
  always_comb begin
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_FILL: in_ready = 1'b1;
      ST_DONE: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Word assembly, pointer and handshake state machine
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_r   <= ST_IDLE;
      mask_r    <= {WIDTH{1'b0}};
      out       <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
      ptr       <= {SEL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (accept_s) begin
            out    <= out_next_s;
            mask_r <= mask_next_s;
            if (auto) begin
              ptr <= ptr + {{(SEL_W-1){1'b0}}, 1'b1};
            end
            // Completion depends only on every index having been written once
            if (full_s) begin
              state_r   <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state_r <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            mask_r    <= {WIDTH{1'b0}};
            ptr       <= {SEL_W{1'b0}};
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          mask_r    <= {WIDTH{1'b0}};
          ptr       <= {SEL_W{1'b0}};
        end
      endcase
    end
  end

`ifdef DEMUX64_PARITY_EN
  logic par_r;

  // Parity of the completed word, captured as the word is finished
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      par_r <= 1'b0;
    end else if (accept_s && full_s) begin
      par_r <= even_par(out_next_s);
    end else begin
      par_r <= par_r;
    end
  end

  assign out_par = par_r;
`else
  assign out_par = 1'b0;
`endif

endmodule
